// File: rtl/seq_wsum_shiftadd_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// seq_wsum_shiftadd_pkg : FSM encodings and width helper for the weighted sum
// Revision 1.0
// ---------------------------------------------------------------------------
package seq_wsum_shiftadd_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

    // Bit-index width; kept at least one bit so CW=1 still elaborates.
    function automatic int kw_of(input int cw);
        return (clog2(cw) < 1) ? 1 : clog2(cw);
    endfunction

endpackage
`default_nettype wire

// File: rtl/seq_wsum_shiftadd_bit_adder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// wsum_bit_adder : sums the channels whose selected coefficient bit is set
// Revision 1.0
// ---------------------------------------------------------------------------
module wsum_bit_adder
    import seq_wsum_shiftadd_pkg::*;
#(
    parameter int N_CH        = 3,
    parameter int DW          = 8,
    parameter int CW          = 5,
    parameter int OW          = 16,
    parameter int SIGNED_DATA = 0,
    parameter int KW          = kw_of(CW)
) (
    input  logic [N_CH*DW-1:0] data,
    input  logic [N_CH*CW-1:0] coef,
    input  logic [KW-1:0]      bit_sel,
    output logic [OW-1:0]      sum
);

    logic [OW-1:0] gated [N_CH];

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic [DW-1:0] x;
        logic [CW-1:0] c;
        logic [OW-1:0] ext;

        assign x = data[i*DW +: DW];
        assign c = coef[i*CW +: CW];

        if (SIGNED_DATA != 0) begin : g_sext
            assign ext = OW'($signed(x));
        end else begin : g_zext
            assign ext = OW'(x);
        end

        assign gated[i] = c[bit_sel] ? ext : '0;
    end

    always_comb begin
        sum = '0;
        for (int i = 0; i < N_CH; i++) begin
            sum = sum + gated[i];
        end
    end

endmodule
`default_nettype wire

// File: rtl/seq_wsum_shiftadd.sv
`default_nettype none
// ---------------------------------------------------------------------------
// seq_wsum_shiftadd : bit-serial (MSB first) runtime-coefficient weighted sum
// Revision 1.0
// ---------------------------------------------------------------------------
module seq_wsum_shiftadd
    import seq_wsum_shiftadd_pkg::*;
#(
    parameter int N_CH        = 3,
    parameter int DW          = 8,
    parameter int CW          = 5,
    parameter int OW          = 16,
    parameter int SIGNED_DATA = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N_CH*DW-1:0]   in_data,
    input  logic [N_CH*CW-1:0]   in_coef,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OW-1:0]        out_data
);

    localparam int KW = kw_of(CW);

    logic [1:0]          state;
    logic [N_CH*DW-1:0]  data_q;
    logic [N_CH*CW-1:0]  coef_q;
    logic [KW-1:0]       k;
    logic [OW-1:0]       acc;
    logic [OW-1:0]       bit_sum;
    logic [OW-1:0]       acc_next;
    logic                accept;

    assign in_ready = (state == ST_IDLE) || ((state == ST_DONE) && out_ready);
    assign accept   = in_valid && in_ready;
    assign acc_next = (acc << 1) + bit_sum;

    wsum_bit_adder #(
        .N_CH        (N_CH),
        .DW          (DW),
        .CW          (CW),
        .OW          (OW),
        .SIGNED_DATA (SIGNED_DATA),
        .KW          (KW)
    ) u_bit_adder (
        .data    (data_q),
        .coef    (coef_q),
        .bit_sel (k),
        .sum     (bit_sum)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            data_q    <= '0;
            coef_q    <= '0;
            k         <= '0;
            acc       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            case (state)
                ST_RUN: begin
                    acc <= acc_next;
                    if (k == '0) begin
                        out_data  <= acc_next;
                        out_valid <= 1'b1;
                        state     <= ST_DONE;
                    end else begin
                        k <= k - 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase

            // A new accept overrides the IDLE return of a same-edge retire.
            if (accept) begin
                data_q <= in_data;
                coef_q <= in_coef;
                acc    <= '0;
                k      <= KW'(CW - 1);
                state  <= ST_RUN;
            end
        end
    end

endmodule
`default_nettype wire
